// File: rtl/core_ctrl_pkg.sv
// Shared types and defaults for the core run/step/breakpoint controller.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    HALT     = 3'd1,
    STEP     = 3'd2,
    RUN      = 3'd3,
    BREAK    = 3'd4
  } run_state_e;

  localparam int unsigned RST_HOLD_CYCLES_DEF = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 250000;
  localparam int unsigned CNT_W_DEF           = 32;
  localparam int unsigned HOLD_W              = 8;

  function automatic logic is_halted(run_state_e s);
    return (s == HALT) || (s == BREAK);
  endfunction

endpackage

// File: rtl/core_run_ctrl_if.sv
// Controller <-> core connection: PC/valid from the core, enable/reset back to it.
interface core_run_ctrl_if;
  logic [31:0] pc_debug;
  logic        insn_vld;
  logic        core_en;
  logic        core_rst;

  modport master (
    input  pc_debug,
    input  insn_vld,
    output core_en,
    output core_rst
  );

  modport slave (
    output pc_debug,
    output insn_vld,
    input  core_en,
    input  core_rst
  );
endinterface

// File: rtl/core_run_ctrl_key_debounce.sv
// Synchronizes and debounces an active-low key; one-cycle pulse per debounced press.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_key_n,
  output logic o_press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            key_meta_q, key_s_q;
  logic            stable_q, stable_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      key_meta_q <= 1'b1;
      key_s_q    <= 1'b1;
    end else begin
      key_meta_q <= i_key_n;
      key_s_q    <= key_meta_q;
    end
  end

  // cnt counts consecutive samples that disagree with the stable level
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (key_s_q != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = key_s_q;
        press_d  = ~key_s_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_press = press_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/step/breakpoint sequencer for the RV32I core: drives core enable/reset
// and counts retired instructions.
module core_run_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES = RST_HOLD_CYCLES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_run_sw,
  input  logic              i_step_key_n,
  input  logic              i_bp_en,
  input  logic [31:0]       i_bp_addr,
  core_run_ctrl_if.master   core,
  output logic              o_halted,
  output logic              o_bp_hit,
  output logic [2:0]        o_state,
  output logic [CNT_W-1:0]  o_insn_cnt
);

  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(RST_HOLD_CYCLES - 1);

  run_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              run_meta_q, run_s;
  logic              step_p;
  logic              bp_match;
  logic              core_en;
  logic              core_rst_q, halted_q, bp_hit_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      run_meta_q <= 1'b0;
      run_s      <= 1'b0;
    end else begin
      run_meta_q <= i_run_sw;
      run_s      <= run_meta_q;
    end
  end

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_step_key (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_key_n (i_step_key_n),
    .o_press (step_p)
  );

  assign bp_match = i_bp_en & core.insn_vld & (core.pc_debug == i_bp_addr);

  // State register plus registered status views of the next state
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= RST_HOLD;
      hold_q     <= '0;
      core_rst_q <= 1'b1;
      halted_q   <= 1'b0;
      bp_hit_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      core_rst_q <= (state_d == RST_HOLD);
      halted_q   <= is_halted(state_d);
      bp_hit_q   <= (state_d == BREAK);
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      RST_HOLD: begin
        if (hold_q == HoldLast) begin
          state_d = run_s ? RUN : HALT;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      HALT: begin
        if (run_s) begin
          state_d = RUN;
        end else if (step_p) begin
          state_d = STEP;
        end
      end
      STEP: state_d = HALT;
      RUN: begin
        // Dropping the switch wins over a coincident breakpoint
        if (!run_s) begin
          state_d = HALT;
        end else if (bp_match) begin
          state_d = BREAK;
        end
      end
      BREAK: begin
        if (!run_s) begin
          state_d = HALT;
        end else if (step_p) begin
          state_d = STEP;
        end
      end
      default: state_d = HALT;
    endcase
  end

  // The breakpointed instruction is held off in RUN but executed by STEP
  always_comb begin
    core_en = 1'b0;
    case (state_q)
      STEP:    core_en = 1'b1;
      RUN:     core_en = ~bp_match;
      default: core_en = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else if (core_en && core.insn_vld) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign core.core_en  = core_en;
  assign core.core_rst = core_rst_q;
  assign o_halted      = halted_q;
  assign o_bp_hit      = bp_hit_q;
  assign o_state       = state_q;
  assign o_insn_cnt    = cnt_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Randomized scoreboard bench for core_run_ctrl against a cycle-level reference model.
module tb_core_run_ctrl;

  localparam int unsigned RH = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run_sw = 1'b0;
  logic          key_n = 1'b1;
  logic          bp_en = 1'b0;
  logic [31:0]   bp_addr = 32'h0;
  logic          halted, bp_hit;
  logic [2:0]    state;
  logic [CW-1:0] insn_cnt;

  core_run_ctrl_if core_bus ();

  core_run_ctrl #(
    .RST_HOLD_CYCLES (RH),
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (CW)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_run_sw     (run_sw),
    .i_step_key_n (key_n),
    .i_bp_en      (bp_en),
    .i_bp_addr    (bp_addr),
    .core         (core_bus.master),
    .o_halted     (halted),
    .o_bp_hit     (bp_hit),
    .o_state      (state),
    .o_insn_cnt   (insn_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic          crst;
    logic          halted;
    logic          hit;
    logic [2:0]    st;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: states 0..4 as numbered, inputs delayed by two samples,
  // key level flips after DB consecutive samples of the opposite value.
  int          m_st, m_hold, m_cnt;
  logic [31:0] m_pc;
  bit          m_run_meta, m_run_s, m_key_meta, m_key_s, m_stable, m_step_p;
  bit          key_hist[$];

  function automatic void model_reset();
    m_st = 0; m_hold = 0; m_cnt = 0; m_pc = 32'h0;
    m_run_meta = 0; m_run_s = 0; m_key_meta = 1; m_key_s = 1;
    m_stable = 1; m_step_p = 0;
    key_hist.delete();
  endfunction

  function automatic void model_eval(bit r, bit run, bit key, bit vld, bit bpe,
                                     logic [31:0] bpa);
    exp_t e;
    bit   bpm, all_opp;
    int   nst;
    if (r) model_reset();
    bpm      = bpe && vld && (m_pc == bpa);
    e.en     = (m_st == 2) || (m_st == 3 && !bpm);
    e.crst   = (m_st == 0);
    e.halted = (m_st == 1) || (m_st == 4);
    e.hit    = (m_st == 4);
    e.st     = 3'(m_st);
    e.cnt    = CW'(m_cnt);
    exp_q.push_back(e);
    if (r) return;
    nst = m_st;
    case (m_st)
      0: if (m_hold == int'(RH) - 1) nst = m_run_s ? 3 : 1; else m_hold++;
      1: if (m_run_s) nst = 3; else if (m_step_p) nst = 2;
      2: nst = 1;
      3: if (!m_run_s) nst = 1; else if (bpm) nst = 4;
      default: if (!m_run_s) nst = 1; else if (m_step_p) nst = 2;
    endcase
    if (e.en && vld) begin
      m_cnt = (m_cnt + 1) % (1 << CW);
      m_pc  = (m_pc + 32'd4) & 32'h3C;
    end
    key_hist.push_back(m_key_s);
    if (key_hist.size() > DB) void'(key_hist.pop_front());
    m_step_p = 0;
    if (key_hist.size() == DB) begin
      all_opp = 1;
      foreach (key_hist[i]) if (key_hist[i] == m_stable) all_opp = 0;
      if (all_opp) begin
        m_stable = !m_stable;
        m_step_p = !m_stable;
      end
    end
    m_run_s = m_run_meta; m_run_meta = run;
    m_key_s = m_key_meta; m_key_meta = key;
    m_st = nst;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  task automatic step_cycle(input bit r, input bit run, input bit key, input bit vld,
                            input bit bpe, input logic [31:0] bpa);
    @(negedge clk);
    rst = r; run_sw = run; key_n = key; bp_en = bpe; bp_addr = bpa;
    core_bus.insn_vld = vld;
    core_bus.pc_debug = m_pc;
    #1;
    model_eval(r, run, key, vld, bpe, bpa);
  endtask

  // Monitor: compare every presented cycle against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("core_en",  32'(core_bus.core_en),  32'(e.en));
        chk("core_rst", 32'(core_bus.core_rst), 32'(e.crst));
        chk("halted",   32'(halted),   32'(e.halted));
        chk("bp_hit",   32'(bp_hit),   32'(e.hit));
        chk("state",    32'(state),    32'(e.st));
        chk("insn_cnt", 32'(insn_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    bit   run_r, key_r, bpe_r;
    int   key_left, rst_left;
    logic [31:0] bpa_r;
    core_bus.pc_debug = 32'h0;
    core_bus.insn_vld = 1'b0;
    model_reset();

    // Reset, then hold with the switch off
    repeat (3) step_cycle(1, 0, 1, 1, 0, 0);
    repeat (8) step_cycle(0, 0, 1, 1, 0, 0);
    // Clean press, release, then a short bounce that must not step
    repeat (10) step_cycle(0, 0, 0, 1, 0, 0);
    repeat (10) step_cycle(0, 0, 1, 1, 0, 0);
    step_cycle(0, 0, 0, 1, 0, 0);
    step_cycle(0, 0, 1, 1, 0, 0);
    step_cycle(0, 0, 0, 1, 0, 0);
    repeat (10) step_cycle(0, 0, 1, 1, 0, 0);
    // Free run without breakpoint, then stop
    repeat (105) step_cycle(0, 1, 1, 1, 0, 0);
    repeat (10) step_cycle(0, 0, 1, 1, 0, 0);
    // Break at 0x10, step over it while the switch stays on, resume
    repeat (3) step_cycle(1, 0, 1, 1, 0, 0);
    repeat (30) step_cycle(0, 1, 1, 1, 1, 32'h10);
    repeat (10) step_cycle(0, 1, 0, 1, 1, 32'h10);
    repeat (25) step_cycle(0, 1, 1, 1, 1, 32'h10);

    // Randomized phase
    run_r = 0; key_r = 1; bpe_r = 0; bpa_r = 32'h10; key_left = 0; rst_left = 0;
    for (int c = 0; c < 2500; c++) begin
      if (key_left == 0) begin
        key_r = !key_r;
        key_left = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3)
                                               : $urandom_range(DB + 3, 14);
      end
      key_left--;
      if ($urandom_range(0, 39) == 0) run_r = !run_r;
      if ($urandom_range(0, 99) == 0) begin
        bpe_r = ($urandom_range(0, 3) != 0);
        bpa_r = ($urandom_range(0, 1) == 0) ? 32'h10 : ($urandom & 32'h3C);
      end
      if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
      step_cycle(rst_left != 0, run_r, key_r, $urandom_range(0, 7) != 0, bpe_r, bpa_r);
      if (rst_left != 0) rst_left--;
    end

    // Reset landing inside a STEP cycle
    repeat (12) step_cycle(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 30; i++) begin
      if (m_st == 2) begin
        step_cycle(1, 0, 0, 1, 0, 0);
        break;
      end
      step_cycle(0, 0, 0, 1, 0, 0);
    end
    repeat (2) step_cycle(1, 0, 1, 1, 0, 0);
    repeat (12) step_cycle(0, 0, 1, 1, 0, 0);

    repeat (2) @(negedge clk);
    #3;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
